// File: rtl/bcd_multi_cntdown.sv
// Multi-digit BCD up/down counter with parallel load, wrap or saturate at the terminal value.
// Optional registered active-low 7-segment outputs via BCD_MULTI_CNTDOWN_SEG7_EN.
module bcd_multi_cntdown #(
  parameter int         DIGITS  = 4,
  parameter int         WRAP    = 1,
  parameter logic [3:0] RST_VAL = 4'd0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  tick,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic                  zero,
  output logic                  tc
`ifdef BCD_MULTI_CNTDOWN_SEG7_EN
  ,
  output logic [7*DIGITS-1:0]   seg7_out
`endif
);

  // Strobe interface, no handshake: load and tick are sampled on every clock edge,
  // load wins over tick, and the result is visible on digits_out one cycle later.

  logic [4*DIGITS-1:0] r_digits;
  logic                r_tc;

  logic [4*DIGITS-1:0] w_cnt;
  logic [4*DIGITS-1:0] w_clamp;
  logic                w_cur_term;
  logic                w_nxt_term;
  logic                w_c;
  logic [3:0]          w_d;
  logic [3:0]          w_n;

  always_comb begin
    w_cnt      = r_digits;
    w_clamp    = '0;
    w_cur_term = 1'b1;
    w_nxt_term = 1'b1;
    w_c        = 1'b1;
    w_d        = 4'd0;
    w_n        = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_d = r_digits[4*i +: 4];
      w_cur_term = w_cur_term & (up ? (w_d == 4'd9) : (w_d == 4'd0));
      // Carry/borrow ripples from digit 0 upward within the cycle.
      if (w_c) begin
        if (up) begin
          w_cnt[4*i +: 4] = (w_d == 4'd9) ? 4'd0 : w_d + 4'd1;
          w_c = (w_d == 4'd9);
        end else begin
          w_cnt[4*i +: 4] = (w_d == 4'd0) ? 4'd9 : w_d - 4'd1;
          w_c = (w_d == 4'd0);
        end
      end
      w_n = w_cnt[4*i +: 4];
      w_nxt_term = w_nxt_term & (up ? (w_n == 4'd9) : (w_n == 4'd0));
      w_clamp[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_digits <= {DIGITS{RST_VAL}};
      r_tc     <= 1'b0;
    end else if (load) begin
      r_digits <= w_clamp;
      r_tc     <= 1'b0;
    end else if (tick && en) begin
      if ((WRAP == 0) && w_cur_term) begin
        r_tc <= 1'b0;
      end else begin
        r_digits <= w_cnt;
        r_tc     <= w_nxt_term;
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign digits_out = r_digits;
  assign tc         = r_tc;
  assign zero       = (r_digits == '0);

`ifdef BCD_MULTI_CNTDOWN_SEG7_EN
  logic [7*DIGITS-1:0] r_seg7;

  // Active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_seg7 <= {DIGITS{seg_of(RST_VAL)}};
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        r_seg7[7*i +: 7] <= seg_of(r_digits[4*i +: 4]);
      end
    end
  end

  assign seg7_out = r_seg7;
`endif

endmodule
